// File: rtl/neopixel_frame_ctrl.sv
`default_nettype none
// ==== neopixel_frame_ctrl : pixel RAM -> MSB-first bit stream + latch interval ==== rev 1.0
module neopixel_frame_ctrl #(
  parameter int PIX_AW = 8,
  parameter int RST_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              frame_start_i,
  input  logic [PIX_AW:0]   reg_pix_num_i,
  input  logic [RST_W-1:0]  reg_rst_time_i,
  output logic              ram_rd_en_o,
  output logic [PIX_AW-1:0] ram_rd_addr_o,
  input  logic [23:0]       ram_rd_data_i,
  output logic              bit_vld_o,
  output logic              bit_data_o,
  input  logic              bit_rdy_i,
  output logic              frame_busy_o,
  output logic              frame_done_o
);

  localparam logic [PIX_AW:0]  PIX_ONE = 1;
  localparam logic [RST_W-1:0] RST_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_AW:0]   pix_num_q, pix_num_d;
  logic [PIX_AW:0]   pix_idx_q, pix_idx_d;
  logic [RST_W-1:0]  rst_time_q, rst_time_d;
  logic [RST_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       nxt_pix_q, nxt_pix_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic              nxt_vld_q, nxt_vld_d;
  logic              pf_pend_q, pf_pend_d;
  logic              first_q, first_d;

  logic [PIX_AW:0]   pix_idx_inc;
  logic [RST_W-1:0]  lat_last;
  logic              pf_issue;

  assign pix_idx_inc = pix_idx_q + PIX_ONE;
  // A zero latch time still spends one cycle in LATCH.
  assign lat_last    = (rst_time_q == '0) ? '0 : (rst_time_q - RST_ONE);
  assign pf_issue    = (state_q == S_SEND) && first_q && (pix_idx_inc < pix_num_q);

  assign ram_rd_en_o   = (state_q == S_FETCH) || pf_issue;
  assign ram_rd_addr_o = pf_issue ? pix_idx_inc[PIX_AW-1:0] : '0;
  assign bit_vld_o     = (state_q == S_SEND);
  assign bit_data_o    = bit_vld_o & shift_q[23];
  assign frame_busy_o  = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                         (state_q == S_SEND)  || (state_q == S_LATCH);
  assign frame_done_o  = (state_q == S_DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      pix_num_q  <= '0;
      pix_idx_q  <= '0;
      rst_time_q <= '0;
      lat_cnt_q  <= '0;
      shift_q    <= '0;
      nxt_pix_q  <= '0;
      bit_idx_q  <= '0;
      nxt_vld_q  <= 1'b0;
      pf_pend_q  <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_num_q  <= pix_num_d;
      pix_idx_q  <= pix_idx_d;
      rst_time_q <= rst_time_d;
      lat_cnt_q  <= lat_cnt_d;
      shift_q    <= shift_d;
      nxt_pix_q  <= nxt_pix_d;
      bit_idx_q  <= bit_idx_d;
      nxt_vld_q  <= nxt_vld_d;
      pf_pend_q  <= pf_pend_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pix_num_d  = pix_num_q;
    pix_idx_d  = pix_idx_q;
    rst_time_d = rst_time_q;
    lat_cnt_d  = lat_cnt_q;
    shift_d    = shift_q;
    nxt_pix_d  = nxt_pix_q;
    bit_idx_d  = bit_idx_q;
    nxt_vld_d  = nxt_vld_q;
    first_d    = 1'b0;
    pf_pend_d  = pf_issue;

    // Prefetched word arrives one cycle after its read strobe.
    if (pf_pend_q) begin
      nxt_pix_d = ram_rd_data_i;
      nxt_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          pix_num_d  = reg_pix_num_i;
          rst_time_d = reg_rst_time_i;
          pix_idx_d  = '0;
          nxt_vld_d  = 1'b0;
          lat_cnt_d  = '0;
          state_d    = (reg_pix_num_i == '0) ? S_LATCH : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d   = ram_rd_data_i;
        bit_idx_d = 5'd23;
        pix_idx_d = '0;
        first_d   = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (bit_rdy_i) begin
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
          end else if (nxt_vld_q) begin
            shift_d   = nxt_pix_q;
            nxt_vld_d = 1'b0;
            bit_idx_d = 5'd23;
            pix_idx_d = pix_idx_inc;
            first_d   = 1'b1;
          end else begin
            lat_cnt_d = '0;
            state_d   = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (lat_cnt_q == lat_last) begin
          lat_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + RST_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_neopixel_frame_ctrl.sv
`default_nettype none
// Directed bench for neopixel_frame_ctrl with a behavioural pixel RAM and bit generator.
module tb_neopixel_frame_ctrl;

  localparam int PIX_AW = 8;
  localparam int RST_W  = 16;

  logic              clk_i          = 1'b0;
  logic              rst_n_i        = 1'b0;
  logic              frame_start_i  = 1'b0;
  logic [PIX_AW:0]   reg_pix_num_i  = '0;
  logic [RST_W-1:0]  reg_rst_time_i = '0;
  logic              ram_rd_en_o;
  logic [PIX_AW-1:0] ram_rd_addr_o;
  logic [23:0]       ram_rd_data_i  = '0;
  logic              bit_vld_o;
  logic              bit_data_o;
  logic              bit_rdy_i      = 1'b0;
  logic              frame_busy_o;
  logic              frame_done_o;

  neopixel_frame_ctrl #(.PIX_AW(PIX_AW), .RST_W(RST_W)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .frame_start_i  (frame_start_i),
    .reg_pix_num_i  (reg_pix_num_i),
    .reg_rst_time_i (reg_rst_time_i),
    .ram_rd_en_o    (ram_rd_en_o),
    .ram_rd_addr_o  (ram_rd_addr_o),
    .ram_rd_data_i  (ram_rd_data_i),
    .bit_vld_o      (bit_vld_o),
    .bit_data_o     (bit_data_o),
    .bit_rdy_i      (bit_rdy_i),
    .frame_busy_o   (frame_busy_o),
    .frame_done_o   (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [23:0]       ram [0:255];
  int                cyc = 0;
  logic              pend = 1'b0;
  logic [PIX_AW-1:0] paddr = '0;
  logic              prev_vld = 1'b0;
  int                busy_cyc = 0;
  int                vld_runs = 0;
  int                done_cnt = 0;
  int                done_q[$];
  logic [PIX_AW-1:0] rd_q[$];
  bit                bits_q[$];
  int                gen_cyc = 7;
  int                stab_err = 0;
  int                last_rdy_cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // RAM data is valid only in the cycle after the strobe; otherwise a poison value.
  always @(negedge clk_i) begin
    ram_rd_data_i = pend ? ram[paddr] : 24'h5A5A5A;
    pend  = ram_rd_en_o;
    paddr = ram_rd_addr_o;
    if (ram_rd_en_o) rd_q.push_back(ram_rd_addr_o);
    if (frame_busy_o) busy_cyc++;
    if (bit_vld_o && !prev_vld) vld_runs++;
    prev_vld = bit_vld_o;
    if (frame_done_o) begin
      done_cnt++;
      done_q.push_back(cyc);
    end
  end

  // Generator: each bit lasts gen_cyc cycles, rdy pulses in the last one.
  initial begin : gen
    logic b;
    forever begin
      @(negedge clk_i);
      bit_rdy_i = 1'b0;
      if (bit_vld_o) begin
        b = bit_data_o;
        bits_q.push_back(b);
        repeat (gen_cyc - 1) begin
          @(negedge clk_i);
          if (bit_vld_o && (bit_data_o !== b)) stab_err++;
        end
        bit_rdy_i    = 1'b1;
        last_rdy_cyc = cyc;
      end
    end
  end

  function automatic logic [23:0] word_at(input int p);
    logic [23:0] w = '0;
    for (int i = 0; i < 24; i++) w[23-i] = bits_q[p*24+i];
    return w;
  endfunction

  task automatic clear_mon();
    busy_cyc = 0;
    vld_runs = 0;
    done_cnt = 0;
    done_q.delete();
    rd_q.delete();
    bits_q.delete();
    stab_err = 0;
  endtask

  task automatic start_frame(input int n, input int rt);
    @(negedge clk_i);
    reg_pix_num_i  = n[PIX_AW:0];
    reg_rst_time_i = rt[RST_W-1:0];
    frame_start_i  = 1'b1;
    @(negedge clk_i);
    frame_start_i  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, "_timeout"}, 64'(done_cnt == 0), 64'd0);
    repeat (3) @(negedge clk_i);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int mis;
    int k;
    for (int i = 0; i < 256; i++) ram[i] = 24'h0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_rd_en", 64'(ram_rd_en_o), 64'd0);
    check("rst_addr",  64'(ram_rd_addr_o), 64'd0);
    check("rst_vld",   64'(bit_vld_o), 64'd0);
    check("rst_data",  64'(bit_data_o), 64'd0);
    check("rst_busy",  64'(frame_busy_o), 64'd0);
    check("rst_done",  64'(frame_done_o), 64'd0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // One pixel, 7-cycle bits, latch 50; registers disturbed mid-frame
    ram[0]  = 24'hA50F81;
    gen_cyc = 7;
    clear_mon();
    start_frame(1, 50);
    check("t1_fetch_en",   64'(ram_rd_en_o), 64'd1);
    check("t1_fetch_addr", 64'(ram_rd_addr_o), 64'd0);
    check("t1_fetch_busy", 64'(frame_busy_o), 64'd1);
    reg_pix_num_i  = 9'd5;
    reg_rst_time_i = 16'd7;
    @(negedge clk_i);
    check("t1_load_vld", 64'(bit_vld_o), 64'd0);
    @(negedge clk_i);
    check("t1_send_vld",  64'(bit_vld_o), 64'd1);
    check("t1_send_data", 64'(bit_data_o), 64'd1);
    wait_done(400, "t1");
    check("t1_nbits", 64'(bits_q.size()), 64'd24);
    check("t1_word",  64'(word_at(0)), 64'h00A50F81);
    check("t1_latch", 64'(done_q[0] - last_rdy_cyc), 64'd51);
    check("t1_runs",  64'(vld_runs), 64'd1);
    check("t1_reads", 64'(rd_q.size()), 64'd1);
    check("t1_busy",  64'(busy_cyc), 64'd220);
    check("t1_ndone", 64'(done_cnt), 64'd1);
    check("t1_stab",  64'(stab_err), 64'd0);

    // Three pixels, gap-free across boundaries
    ram[0] = 24'hFFFFFF;
    ram[1] = 24'h000000;
    ram[2] = 24'h123456;
    clear_mon();
    start_frame(3, 20);
    wait_done(1000, "t2");
    check("t2_nbits", 64'(bits_q.size()), 64'd72);
    check("t2_w0",    64'(word_at(0)), 64'h00FFFFFF);
    check("t2_w1",    64'(word_at(1)), 64'h00000000);
    check("t2_w2",    64'(word_at(2)), 64'h00123456);
    check("t2_runs",  64'(vld_runs), 64'd1);
    check("t2_reads", 64'(rd_q.size()), 64'd3);
    mis = 0;
    foreach (rd_q[i]) if (int'(rd_q[i]) != i) mis++;
    check("t2_addr",  64'(mis), 64'd0);
    check("t2_latch", 64'(done_q[0] - last_rdy_cyc), 64'd21);
    check("t2_stab",  64'(stab_err), 64'd0);

    // Empty frame
    clear_mon();
    start_frame(0, 10);
    check("t3_rd_en", 64'(ram_rd_en_o), 64'd0);
    wait_done(100, "t3");
    check("t3_busy",  64'(busy_cyc), 64'd10);
    check("t3_reads", 64'(rd_q.size()), 64'd0);
    check("t3_runs",  64'(vld_runs), 64'd0);
    check("t3_ndone", 64'(done_cnt), 64'd1);

    // Zero latch time
    clear_mon();
    start_frame(0, 0);
    wait_done(50, "t4a");
    check("t4a_busy", 64'(busy_cyc), 64'd1);
    clear_mon();
    ram[0] = 24'h800001;
    start_frame(1, 0);
    wait_done(400, "t4b");
    check("t4b_latch", 64'(done_q[0] - last_rdy_cyc), 64'd2);
    check("t4b_word",  64'(word_at(0)), 64'h00800001);

    // Start held high: one frame per IDLE visit, period = latch + DONE + IDLE
    clear_mon();
    @(negedge clk_i);
    reg_pix_num_i  = '0;
    reg_rst_time_i = 16'd3;
    frame_start_i  = 1'b1;
    repeat (30) @(negedge clk_i);
    frame_start_i  = 1'b0;
    repeat (10) @(negedge clk_i);
    check("t5_frames", 64'(done_q.size() >= 3), 64'd1);
    check("t5_gap01",  64'(done_q[1] - done_q[0]), 64'd5);
    check("t5_gap12",  64'(done_q[2] - done_q[1]), 64'd5);

    // Asynchronous reset in the middle of pixel 1
    ram[0] = 24'hFFFFFF;
    ram[1] = 24'h000000;
    ram[2] = 24'h123456;
    clear_mon();
    start_frame(3, 20);
    k = 0;
    while (bits_q.size() < 35 && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    check("t6_reach", 64'(bits_q.size() >= 35), 64'd1);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check("t6_outs", 64'({ram_rd_en_o, ram_rd_addr_o, bit_vld_o, bit_data_o,
                          frame_busy_o, frame_done_o}), 64'd0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    done_cnt = 0;
    repeat (20) @(negedge clk_i);
    check("t6_nodone", 64'(done_cnt), 64'd0);
    clear_mon();
    start_frame(3, 20);
    wait_done(1000, "t6");
    check("t6_nbits", 64'(bits_q.size()), 64'd72);
    check("t6_w0",    64'(word_at(0)), 64'h00FFFFFF);
    check("t6_w2",    64'(word_at(2)), 64'h00123456);
    check("t6_addr0", 64'(rd_q[0]), 64'd0);
    check("t6_reads", 64'(rd_q.size()), 64'd3);

    // Full 256-pixel frame at the minimum 2-cycle bit time
    for (int i = 0; i < 256; i++) ram[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h3C};
    gen_cyc = 2;
    repeat (5) @(negedge clk_i);
    clear_mon();
    start_frame(256, 5);
    wait_done(20000, "t7");
    check("t7_nbits", 64'(bits_q.size()), 64'd6144);
    mis = 0;
    for (int p = 0; p < 256; p++) if (word_at(p) !== ram[p]) mis++;
    check("t7_words", 64'(mis), 64'd0);
    check("t7_reads", 64'(rd_q.size()), 64'd256);
    mis = 0;
    foreach (rd_q[i]) if (int'(rd_q[i]) != i) mis++;
    check("t7_addr",  64'(mis), 64'd0);
    check("t7_runs",  64'(vld_runs), 64'd1);
    check("t7_ndone", 64'(done_cnt), 64'd1);
    check("t7_latch", 64'(done_q[0] - last_rdy_cyc), 64'd6);
    check("t7_stab",  64'(stab_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
